inst_fetch_responder: RTL and testbench

//  Responder end of the CPU instruction-fetch port (rom_ce/inst_addr -> inst).

---
 rtl/inst_fetch_responder_pkg.sv | 16 +
 rtl/inst_fetch_responder_if.sv | 28 ++
 rtl/inst_fetch_responder_line_buf.sv | 46 ++++
 rtl/inst_fetch_responder.sv | 112 +++++++++++
 tb/tb_inst_fetch_responder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_responder_pkg.sv
// Shared widths, state encoding and field types for the instruction-fetch responder.
// The line geometry is fixed here so the interface, buffer and top all agree.
package inst_fetch_responder_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam int TAG_W      = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {FS_IDLE, FS_REQ, FS_FILL} fetch_state_t;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Fetch port (CPU side) and burst port (backing memory side) of the responder.
// Master is the surrounding SOPC; slave is the responder itself.
interface inst_fetch_responder_if;
  import inst_fetch_responder_pkg::*;

  logic              rom_ce;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst;
  logic              stall_req;
  logic              flush;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output rom_ce, inst_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    input  inst, stall_req, mem_req, mem_addr
  );

  modport slave (
    input  rom_ce, inst_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    output inst, stall_req, mem_req, mem_addr
  );

endinterface

// File: rtl/inst_fetch_responder_line_buf.sv
// One-line instruction buffer: word storage, stored tag, valid bit and tag compare.
// Word storage is intentionally not reset; only the valid bit guards its contents.
module inst_fetch_responder_line_buf
  import inst_fetch_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  idx_t              wrIdx_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  idx_t              rdIdx_i,
  output logic [DATA_W-1:0] rdData_o,
  input  logic              setValid_i,
  input  logic              clrValid_i,
  input  tag_t              setTag_i,
  input  tag_t              cmpTag_i,
  output logic              hit_o
);

  logic [DATA_W-1:0] line_q [LINE_WORDS];
  tag_t              tag_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      line_q[wrIdx_i] <= wrData_i;
    end
  end

  // Setting wins over clearing: a completing refill always publishes its tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (setValid_i) begin
      valid_q <= 1'b1;
      tag_q   <= setTag_i;
    end else if (clrValid_i) begin
      valid_q <= 1'b0;
    end
  end

  assign rdData_o = line_q[rdIdx_i];
  assign hit_o    = valid_q && (tag_q == cmpTag_i);

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: zero-latency hits from a one-line buffer, and on a
// miss a stalled burst refill from backing memory (IDLE -> REQ -> FILL -> IDLE).
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  inst_fetch_responder_if.slave bus
);

  fetch_state_t      state_q, state_d;
  idx_t              cnt_q, cnt_d;
  tag_t              reqTag_q, reqTag_d;
  logic              flushPend_q, flushPend_d;

  tag_t              fetchTag;
  idx_t              fetchIdx;
  logic              lineHit;
  logic              fetchMiss;
  logic              beatIn;
  logic              lastBeat;
  logic              setValid;
  logic              clrValid;
  logic [DATA_W-1:0] lineWord;
  logic              unused_addrBits;

  assign fetchTag        = bus.inst_addr[ADDR_W-1:IDX_W+2];
  assign fetchIdx        = bus.inst_addr[IDX_W+1:2];
  assign unused_addrBits = ^bus.inst_addr[1:0];

  assign fetchMiss = bus.rom_ce && (state_q == FS_IDLE) && !lineHit;
  assign beatIn    = (state_q == FS_FILL) && bus.mem_rvalid;
  assign lastBeat  = beatIn && (cnt_q == idx_t'(LINE_WORDS - 1));

  // A flush seen at any point of the burst, including the last beat, keeps the line invalid.
  assign setValid  = lastBeat && !(flushPend_q || bus.flush);
  assign clrValid  = (state_q == FS_IDLE) && (bus.flush || fetchMiss);

  inst_fetch_responder_line_buf u_lineBuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (beatIn),
    .wrIdx_i    (cnt_q),
    .wrData_i   (bus.mem_rdata),
    .rdIdx_i    (fetchIdx),
    .rdData_o   (lineWord),
    .setValid_i (setValid),
    .clrValid_i (clrValid),
    .setTag_i   (reqTag_q),
    .cmpTag_i   (fetchTag),
    .hit_o      (lineHit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_IDLE;
      cnt_q       <= '0;
      reqTag_q    <= '0;
      flushPend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reqTag_q    <= reqTag_d;
      flushPend_q <= flushPend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reqTag_d    = reqTag_q;
    flushPend_d = flushPend_q;
    unique case (state_q)
      FS_IDLE: begin
        if (fetchMiss) begin
          state_d  = FS_REQ;
          reqTag_d = fetchTag;
        end
      end
      FS_REQ: begin
        if (bus.flush) flushPend_d = 1'b1;
        if (bus.mem_gnt) state_d = FS_FILL;
      end
      FS_FILL: begin
        if (bus.flush) flushPend_d = 1'b1;
        if (beatIn) cnt_d = cnt_q + idx_t'(1);
        if (lastBeat) begin
          state_d     = FS_IDLE;
          flushPend_d = 1'b0;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  // Fetch outputs are forced quiet while reset is held, even with rom_ce high.
  always_comb begin
    bus.inst      = '0;
    bus.stall_req = 1'b0;
    bus.mem_req   = (state_q == FS_REQ);
    if (rst_n && bus.rom_ce) begin
      if ((state_q == FS_IDLE) && lineHit) begin
        bus.inst = lineWord;
      end else begin
        bus.stall_req = 1'b1;
      end
    end
  end

  assign bus.mem_addr = {reqTag_q, {(IDX_W + 2){1'b0}}};

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: the bench plays both the CPU fetch side
// and the backing memory, with hand-computed expected instructions and addresses.
module tb_inst_fetch_responder;
  import inst_fetch_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   errorCount = 0;

  inst_fetch_responder_if bus ();

  inst_fetch_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Moves to just after the next rising edge; inputs change here, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic romCe, input logic [31:0] addr, input logic flushIn);
    bus.rom_ce    = romCe;
    bus.inst_addr = addr;
    bus.flush     = flushIn;
    #1;
  endtask

  // Entered in the IDLE cycle where a miss is presented; returns in the first IDLE cycle after the burst.
  task automatic serveMiss(input string tag, input logic [31:0] expAddr, input int gntWait,
                           input logic [127:0] beats, input int switchBeat,
                           input logic [31:0] switchAddr, input int flushBeat);
    checkOutput({tag, " miss stall"}, 32'(bus.stall_req), 32'd1);
    checkOutput({tag, " no req in idle"}, 32'(bus.mem_req), 32'd0);
    for (int w = 0; w <= gntWait; w++) begin
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_gnt    = (w == gntWait);
      #1;
      checkOutput({tag, " mem_req"}, 32'(bus.mem_req), 32'd1);
      checkOutput({tag, " mem_addr"}, bus.mem_addr, expAddr);
      checkOutput({tag, " stall in req"}, 32'(bus.stall_req), 32'd1);
    end
    for (int b = 0; b < LINE_WORDS; b++) begin
      tick();
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = beats[b*32 +: 32];
      bus.flush      = (b == flushBeat);
      if (b == switchBeat) bus.inst_addr = switchAddr;
      #1;
      checkOutput({tag, " stall in fill"}, 32'(bus.stall_req), 32'd1);
      checkOutput({tag, " req dropped"}, 32'(bus.mem_req), 32'd0);
    end
    tick();
    bus.mem_rvalid = 1'b0;
    bus.flush      = 1'b0;
  endtask

  initial begin
    logic [127:0] lineF;
    lineF = {32'hF4, 32'hF3, 32'hF2, 32'hF1};

    rst_n          = 1'b0;
    bus.rom_ce     = 1'b0;
    bus.inst_addr  = '0;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    #1;
    checkOutput("reset inst", bus.inst, 32'h0);
    checkOutput("reset stall", 32'(bus.stall_req), 32'd0);
    checkOutput("reset mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Cold miss at 0x8 with grant on the second request cycle.
    tick();
    applyStimulus(1'b1, 32'h8, 1'b0);
    serveMiss("cold", 32'h0, 1, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 32'h0, -1);
    applyStimulus(1'b1, 32'h8, 1'b0);
    checkOutput("cold first hit inst", bus.inst, 32'h33);
    checkOutput("cold first hit stall", 32'(bus.stall_req), 32'd0);

    // Streaming hits across the whole line, then a miss on the next line.
    for (int i = 0; i < 4; i++) begin
      tick();
      applyStimulus(1'b1, 32'(i * 4), 1'b0);
      checkOutput("stream inst", bus.inst, 32'(32'h11 * (i + 1)));
      checkOutput("stream stall", 32'(bus.stall_req), 32'd0);
      checkOutput("stream mem_req", 32'(bus.mem_req), 32'd0);
    end
    tick();
    applyStimulus(1'b1, 32'h10, 1'b0);
    serveMiss("line10", 32'h10, 0, {32'h88, 32'h77, 32'h66, 32'h55}, -1, 32'h0, -1);
    applyStimulus(1'b1, 32'h14, 1'b0);
    checkOutput("line10 hit inst", bus.inst, 32'h66);

    // Address moves to another line during the fill; the old burst still completes first.
    tick();
    applyStimulus(1'b1, 32'h4, 1'b0);
    serveMiss("switch first", 32'h0, 0, {32'h0404, 32'h0303, 32'h0202, 32'h0101}, 1, 32'h24, -1);
    applyStimulus(1'b1, 32'h24, 1'b0);
    serveMiss("switch second", 32'h20, 2, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, -1, 32'h0, -1);
    applyStimulus(1'b1, 32'h24, 1'b0);
    checkOutput("switch new line inst", bus.inst, 32'hC2);
    checkOutput("switch new line stall", 32'(bus.stall_req), 32'd0);

    // Flush during fill forces a refetch of the same line.
    tick();
    applyStimulus(1'b1, 32'h40, 1'b0);
    serveMiss("flush in fill", 32'h40, 0, {32'hE4, 32'hE3, 32'hE2, 32'hE1}, -1, 32'h0, 2);
    applyStimulus(1'b1, 32'h40, 1'b0);
    serveMiss("refetch", 32'h40, 0, lineF, -1, 32'h0, -1);

    // Flush in IDLE together with a hit: word still returned, then the line misses.
    applyStimulus(1'b1, 32'h48, 1'b1);
    checkOutput("flush+hit inst", bus.inst, 32'hF3);
    checkOutput("flush+hit stall", 32'(bus.stall_req), 32'd0);
    tick();
    applyStimulus(1'b1, 32'h48, 1'b0);
    serveMiss("after idle flush", 32'h40, 0, lineF, -1, 32'h0, -1);
    applyStimulus(1'b1, 32'h4C, 1'b0);
    checkOutput("after idle flush inst", bus.inst, 32'hF4);

    // rom_ce low returns nothing; stray beats in IDLE must not touch the line.
    tick();
    applyStimulus(1'b0, 32'h44, 1'b0);
    checkOutput("ce low inst", bus.inst, 32'h0);
    checkOutput("ce low stall", 32'(bus.stall_req), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    repeat (3) begin
      tick();
      checkOutput("stray beat no req", 32'(bus.mem_req), 32'd0);
    end
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      applyStimulus(1'b1, 32'(32'h40 + i * 4), 1'b0);
      checkOutput("stray reread inst", bus.inst, lineF[i*32 +: 32]);
      checkOutput("stray reread stall", 32'(bus.stall_req), 32'd0);
    end

    // Reset asserted mid-burst clears outputs immediately; a stale beat afterwards is ignored.
    tick();
    applyStimulus(1'b1, 32'h80, 1'b0);
    tick();
    checkOutput("pre-reset mem_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset inst", bus.inst, 32'h0);
    checkOutput("mid reset stall", 32'(bus.stall_req), 32'd0);
    checkOutput("mid reset mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("mid reset mem_addr", bus.mem_addr, 32'h0);
    tick();
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_0BAD;
    applyStimulus(1'b1, 32'h80, 1'b0);
    serveMiss("post reset", 32'h80, 0, {32'h94, 32'h93, 32'h92, 32'h91}, -1, 32'h0, -1);
    applyStimulus(1'b1, 32'h88, 1'b0);
    checkOutput("post reset hit inst", bus.inst, 32'h93);
    checkOutput("post reset hit stall", 32'(bus.stall_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
